cnn_layer_accel_weight_seq_addr_gen: RTL and testbench
======================================================

// Module: cnn_layer_accel_weight_seq_addr_gen
// PURPOSE
// - Upstream driver of the AWE weight-sequence data tables: generates rdAddr/rden to walk one sequence
//   window [cfg_base, cfg_base+cfg_len-1] cfg_rep times, honouring downstream stall.
// - Emits seq_valid/seq_last aligned to the tables' registered seq_dout0/seq_dout1 so the consumer samples
//   table data without its own delay matching. One instance per AWE; start/done handshake to layer ctrl.
// PARAMETERS
// - C_NUM_SEQ_VALUES   `NUM_WHT_SEQ_VALUES   table depth; C_RDADDR_WIDTH = clog2(C_NUM_SEQ_VALUES)
// - C_LEN_WIDTH        clog2(C_NUM_SEQ_VALUES+1)   width of cfg_len
// - C_REP_WIDTH        16                    width of cfg_rep
// - C_TABLE_LATENCY    1                     rden-to-seq_dout cycles of the data tables (1 or 2)
// PORTS
// - clk         in   1                 single clock, all logic rising-edge
// - rst         in   1                 synchronous, active-high reset
// - start       in   1                 1-cycle pulse; latches cfg_* when in IDLE
// - cfg_base    in   C_RDADDR_WIDTH    first table address of sequence window
// - cfg_len     in   C_LEN_WIDTH       entries per pass, legal 1..C_NUM_SEQ_VALUES
// - cfg_rep     in   C_REP_WIDTH       number of passes, legal >=1
// - stall       in   1                 consumer back-pressure; 1 = do not issue a read this cycle
// - rdAddr      out  C_RDADDR_WIDTH    table read address
// - rden        out  1                 table read enable
// - seq_valid   out  1                 table outputs valid this cycle (rden delayed C_TABLE_LATENCY)
// - seq_last    out  1                 with seq_valid: last entry of final pass
// - busy        out  1                 high from accepted start until done
// - done        out  1                 1-cycle pulse after final seq_valid, or on rejected config
// - cfg_err     out  1                 1-cycle pulse with done when config illegal
// BEHAVIOUR
// - Reset: all outputs 0, rdAddr=0, FSM=IDLE, delay pipes cleared; reset mid-run aborts, no done pulse.
// - FSM: IDLE -start-> CHECK -> RUN -final read-> DRAIN -last valid out-> DONE -> IDLE.
// - IDLE: start latches cfg_*; start while not IDLE ignored (no re-latch, no error).
// - CHECK (1 cycle): illegal if cfg_len==0, cfg_rep==0, or cfg_base+cfg_len > C_NUM_SEQ_VALUES
//   (compare at C_RDADDR_WIDTH+1 bits) -> DONE with cfg_err=1, zero reads issued.
// - RUN: rden = !stall (combinational on stall, registered-free path forbidden: rden/rdAddr are registered,
//   issue decision uses stall of previous cycle is NOT allowed) -> rden=1 and rdAddr valid in same cycle
//   stall=0 observed; rdAddr holds while stall=1.
// - Address counter: rdAddr advances base..base+len-1 then wraps to base; pass counter decrements on wrap.
//   Last read of last pass -> DRAIN. Total reads = cfg_len*cfg_rep exactly, in order, no gaps except stall.
// - cfg_len==1: rdAddr constant at base, cfg_rep reads.
// - seq_valid/seq_last: shift of (rden, final-read flag) by C_TABLE_LATENCY; stall does not freeze pipe.
// - DRAIN: waits until seq_last seen; DONE: done=1 one cycle, busy drops same cycle, then IDLE.
// - done for legal run: exactly 1 cycle after seq_last. busy=1 in CHECK/RUN/DRAIN/DONE.
// - start asserted in the DONE cycle is ignored; earliest new start accepted the cycle after done.
// - Pass counter and read counter widths: C_REP_WIDTH and C_LEN_WIDTH; no overflow possible for legal cfg.
// STRUCTURE
// - Shared package/header (cnn_layer_accel_defs.vh): FSM state encodings ST_WSAG_IDLE..ST_WSAG_DONE,
//   C_WHT_SEQ_TABLE_LATENCY constant, reuse `NUM_WHT_SEQ_VALUES.
// - One sub-module: cnn_layer_accel_valid_delay_pipe (parametric depth shift of {valid,last}, sync reset).
// - FSM + address/pass counters in this file; no memories.
// TESTING  (bench: C_NUM_SEQ_VALUES=32, C_TABLE_LATENCY=1, table model returning data=addr)
// - base=4,len=3,rep=2, no stall -> rdAddr 4,5,6,4,5,6 on 6 consecutive cycles; seq_valid 6 cycles
//   lagging by 1; seq_last on 6th; done 1 cycle later; busy low after done.
// - Same cfg, stall high on 2nd and 4th issue cycles -> identical address order, 8 RUN cycles, no
//   duplicated/lost reads, seq_valid count 6.
// - base=30,len=3,rep=1 -> cfg_err=1 and done=1 together, rden never asserted; len=0 and rep=0 same.
// - base=31,len=1,rep=3 -> rdAddr 31 three times; len=32,base=0,rep=1 -> 0..31 then done.
// - Second start pulsed mid-run with different cfg -> ignored; output stream matches first cfg only.
// - rst asserted during RUN after 2 reads -> next cycle all outputs 0, no done; fresh start runs clean.

Source files
------------

// File: rtl/cnn_layer_accel_weight_seq_addr_gen_pkg.sv
// Shared constants and FSM encoding for the AWE weight-sequence address generator.
package cnn_layer_accel_weight_seq_addr_gen_pkg;

  localparam int NUM_WHT_SEQ_VALUES      = 32;
  localparam int C_WHT_SEQ_TABLE_LATENCY = 1;

  typedef enum logic [2:0] {
    ST_WSAG_IDLE  = 3'd0,
    ST_WSAG_CHECK = 3'd1,
    ST_WSAG_RUN   = 3'd2,
    ST_WSAG_DRAIN = 3'd3,
    ST_WSAG_DONE  = 3'd4
  } wsag_state_t;

endpackage

// File: rtl/cnn_layer_accel_weight_seq_addr_gen_if.sv
// Layer-control config/handshake plus table read port and consumer-side valid strobes.
interface cnn_layer_accel_weight_seq_addr_gen_if
  import cnn_layer_accel_weight_seq_addr_gen_pkg::*;
#(
  parameter int C_RDADDR_WIDTH = $clog2(NUM_WHT_SEQ_VALUES),
  parameter int C_LEN_WIDTH    = $clog2(NUM_WHT_SEQ_VALUES + 1),
  parameter int C_REP_WIDTH    = 16
);
  // Handshake: start is a 1-cycle request honoured only while idle; busy spans
  // accept..done; done is a 1-cycle pulse; rden is the table read strobe and
  // seq_valid marks the cycle its data appears on the table outputs.
  logic                      start;
  logic [C_RDADDR_WIDTH-1:0] cfg_base;
  logic [C_LEN_WIDTH-1:0]    cfg_len;
  logic [C_REP_WIDTH-1:0]    cfg_rep;
  logic                      stall;
  logic [C_RDADDR_WIDTH-1:0] rdAddr;
  logic                      rden;
  logic                      seq_valid;
  logic                      seq_last;
  logic                      busy;
  logic                      done;
  logic                      cfg_err;

  modport master (
    output start, cfg_base, cfg_len, cfg_rep, stall,
    input  rdAddr, rden, seq_valid, seq_last, busy, done, cfg_err
  );

  modport slave (
    input  start, cfg_base, cfg_len, cfg_rep, stall,
    output rdAddr, rden, seq_valid, seq_last, busy, done, cfg_err
  );

endinterface

// File: rtl/cnn_layer_accel_weight_seq_addr_gen_valid_delay_pipe.sv
// Fixed-depth shift of {valid,last} so strobes line up with registered table outputs.
module cnn_layer_accel_valid_delay_pipe #(
  parameter int C_DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [C_DEPTH-1:0][1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = {in_valid, in_last};
    for (int i = 1; i < C_DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign out_valid = pipe_q[C_DEPTH-1][1];
  assign out_last  = pipe_q[C_DEPTH-1][0];

endmodule

// File: rtl/cnn_layer_accel_weight_seq_addr_gen.sv
// Walks the window [base, base+len-1] rep times over the weight-sequence tables,
// issuing one read per non-stalled cycle, then reports done to layer control.
module cnn_layer_accel_weight_seq_addr_gen
  import cnn_layer_accel_weight_seq_addr_gen_pkg::*;
#(
  parameter int C_NUM_SEQ_VALUES = NUM_WHT_SEQ_VALUES,
  parameter int C_RDADDR_WIDTH   = $clog2(C_NUM_SEQ_VALUES),
  parameter int C_LEN_WIDTH      = $clog2(C_NUM_SEQ_VALUES + 1),
  parameter int C_REP_WIDTH      = 16,
  parameter int C_TABLE_LATENCY  = C_WHT_SEQ_TABLE_LATENCY
) (
  input  logic                                   clk,
  input  logic                                   rst,
  cnn_layer_accel_weight_seq_addr_gen_if.slave   bus,
  output wsag_state_t                            dbg_state
);

  localparam int SW = C_RDADDR_WIDTH + 1;

  wsag_state_t               state_q, state_d;
  logic [C_RDADDR_WIDTH-1:0] base_q, base_d;
  logic [C_LEN_WIDTH-1:0]    len_q, len_d;
  logic [C_RDADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_LEN_WIDTH-1:0]    idx_q, idx_d;
  logic [C_REP_WIDTH-1:0]    pass_q, pass_d;
  logic                      err_q, err_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      cfg_err_q, cfg_err_d;
  logic                      rden, final_rd, pass_end, illegal;
  logic                      pipe_valid, pipe_last;

  // Reads are issued in the same cycle stall is seen low; the address itself is registered.
  assign rden     = (state_q == ST_WSAG_RUN) && !bus.stall;
  assign pass_end = (idx_q == len_q - C_LEN_WIDTH'(1));
  assign final_rd = rden && pass_end && (pass_q == C_REP_WIDTH'(1));
  assign illegal  = (len_q == '0) || (pass_q == '0) ||
                    ((SW'(base_q) + SW'(len_q)) > SW'(C_NUM_SEQ_VALUES));

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    err_d   = err_q;
    case (state_q)
      ST_WSAG_IDLE: begin
        if (bus.start) begin
          base_d  = bus.cfg_base;
          len_d   = bus.cfg_len;
          addr_d  = bus.cfg_base;
          idx_d   = '0;
          pass_d  = bus.cfg_rep;
          state_d = ST_WSAG_CHECK;
        end
      end
      ST_WSAG_CHECK: begin
        err_d   = illegal;
        state_d = illegal ? ST_WSAG_DONE : ST_WSAG_RUN;
      end
      ST_WSAG_RUN: begin
        if (rden) begin
          if (pass_end) begin
            idx_d  = '0;
            addr_d = base_q;
            pass_d = pass_q - C_REP_WIDTH'(1);
          end else begin
            idx_d  = idx_q + C_LEN_WIDTH'(1);
            addr_d = addr_q + C_RDADDR_WIDTH'(1);
          end
          if (final_rd) state_d = ST_WSAG_DRAIN;
        end
      end
      ST_WSAG_DRAIN: begin
        if (pipe_last) state_d = ST_WSAG_DONE;
      end
      ST_WSAG_DONE: begin
        err_d   = 1'b0;
        state_d = ST_WSAG_IDLE;
      end
      default: state_d = ST_WSAG_IDLE;
    endcase
    busy_d    = (state_d != ST_WSAG_IDLE);
    done_d    = (state_d == ST_WSAG_DONE);
    cfg_err_d = (state_d == ST_WSAG_DONE) && err_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_WSAG_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  cnn_layer_accel_valid_delay_pipe #(
    .C_DEPTH (C_TABLE_LATENCY)
  ) u_valid_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rden),
    .in_last   (final_rd),
    .out_valid (pipe_valid),
    .out_last  (pipe_last)
  );

  assign bus.rdAddr    = addr_q;
  assign bus.rden      = rden;
  assign bus.seq_valid = pipe_valid;
  assign bus.seq_last  = pipe_last;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_cnn_layer_accel_weight_seq_addr_gen.sv
// Directed bench: queue-based read-order model, per-cycle strobe checks, literal timing pins.
module tb_cnn_layer_accel_weight_seq_addr_gen;
  import cnn_layer_accel_weight_seq_addr_gen_pkg::*;

  logic        clk;
  logic        rst;
  wsag_state_t dbg_state;
  int          tests;
  int          fails;
  int          cyc;

  cnn_layer_accel_weight_seq_addr_gen_if #(.C_RDADDR_WIDTH(5), .C_LEN_WIDTH(6), .C_REP_WIDTH(16)) bus ();

  cnn_layer_accel_weight_seq_addr_gen #(
    .C_NUM_SEQ_VALUES (32),
    .C_TABLE_LATENCY  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // model / scoreboard state
  logic [4:0] exp_q[$];
  logic [4:0] obs_q[$];
  int  total, n_rden, n_valid;
  int  first_rd, last_rd, last_cyc, done_cyc, start_cyc;
  bit  err_mode, chk_en, prev_rden, prev_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // compare process: every cycle, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst || !chk_en) begin
        prev_rden = 1'b0;
        prev_last = 1'b0;
      end else begin
        if (bus.rden) begin
          if (first_rd < 0) first_rd = cyc;
          last_rd = cyc;
          n_rden++;
          obs_q.push_back(bus.rdAddr);
          if (exp_q.size() == 0) chk("rd_extra", 1, 0);
          else                   chk("rd_addr", bus.rdAddr, exp_q.pop_front());
        end
        chk("seq_valid", bus.seq_valid, prev_rden);
        if (bus.seq_valid) n_valid++;
        chk("seq_last", bus.seq_last, bus.seq_valid && total > 0 && n_valid == total);
        if (!err_mode) chk("done_after_last", bus.done, prev_last);
        chk("cfg_err", bus.cfg_err, bus.done && err_mode);
        if (bus.seq_last) last_cyc = cyc;
        prev_rden = bus.rden;
        prev_last = bus.seq_last;
      end
    end
  end

  // driver: one configuration from start to done
  task automatic run_cfg(input int base, input int len, input int rep, input logic [31:0] stall_mask,
                         input int restart_at, input bit start_in_done, input bit exp_err, input int exp_span);
    bit got;
    exp_q.delete();
    obs_q.delete();
    total = exp_err ? 0 : len * rep;
    if (!exp_err)
      for (int p = 0; p < rep; p++)
        for (int i = 0; i < len; i++) exp_q.push_back(5'(base + i));
    n_rden = 0; n_valid = 0; err_mode = exp_err;
    first_rd = -1; last_rd = -1; last_cyc = -1; done_cyc = -1;
    @(posedge clk); #1;
    bus.cfg_base = 5'(base); bus.cfg_len = 6'(len); bus.cfg_rep = 16'(rep);
    bus.start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        got = 1'b1;
        done_cyc = cyc;
        chk("busy_in_done", bus.busy, 1);
        chk("cfg_err_with_done", bus.cfg_err, exp_err);
        if (exp_err) chk("err_done_latency", cyc - start_cyc, 2);
        else         chk("done_latency", cyc - last_cyc, 1);
        bus.stall = 1'b0;
        if (start_in_done) begin
          bus.cfg_base = 5'd0; bus.cfg_len = 6'd1; bus.cfg_rep = 16'd1; bus.start = 1'b1;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_after_done", bus.busy, 0);
        chk("done_pulse_width", bus.done, 0);
      end else begin
        bus.stall = (c < 32) ? stall_mask[c] : 1'b0;
        bus.start = (c == restart_at);
        if (c == restart_at) begin
          bus.cfg_base = 5'd10; bus.cfg_len = 6'd2; bus.cfg_rep = 16'd1;
        end
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    chk("read_count", n_rden, total);
    chk("valid_count", n_valid, total);
    chk("model_drained", exp_q.size(), 0);
    if (!exp_err) begin
      chk("first_read_latency", first_rd - start_cyc, 2);
      chk("read_span", last_rd - first_rd + 1, exp_span);
    end
  endtask

  initial begin
    logic [4:0] lit_t1 [6];
    lit_t1 = '{5'd4, 5'd5, 5'd6, 5'd4, 5'd5, 5'd6};
    tests = 0; fails = 0; cyc = 0; chk_en = 1'b0; total = 0; err_mode = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0; bus.cfg_base = '0; bus.cfg_len = '0; bus.cfg_rep = '0; bus.stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outputs", {bus.rdAddr, bus.rden, bus.seq_valid, bus.seq_last, bus.busy, bus.done, bus.cfg_err}, 0);
    chk_en = 1'b1;

    // basic two-pass walk, pinned against hand-computed literals
    run_cfg(4, 3, 2, 32'h0, -1, 1'b0, 1'b0, 6);
    chk("t1_obs_len", obs_q.size(), 6);
    for (int i = 0; i < 6 && i < obs_q.size(); i++) chk("t1_addr_literal", obs_q[i], lit_t1[i]);
    chk("t1_done_cycle", done_cyc - start_cyc, 9);

    // stall on 2nd and 4th issue cycles
    run_cfg(4, 3, 2, 32'b1010, -1, 1'b0, 1'b0, 8);
    chk("t2_done_cycle", done_cyc - start_cyc, 11);
    for (int i = 0; i < 6 && i < obs_q.size(); i++) chk("t2_addr_literal", obs_q[i], lit_t1[i]);

    // illegal configurations
    run_cfg(30, 3, 1, 32'h0, -1, 1'b0, 1'b1, 0);
    run_cfg(0, 0, 1, 32'h0, -1, 1'b0, 1'b1, 0);
    run_cfg(0, 3, 0, 32'h0, -1, 1'b0, 1'b1, 0);

    // boundaries: window touching the top, single entry, full table
    run_cfg(29, 3, 1, 32'h0, -1, 1'b0, 1'b0, 3);
    run_cfg(31, 1, 3, 32'h0, -1, 1'b0, 1'b0, 3);
    chk("len1_obs_len", obs_q.size(), 3);
    if (obs_q.size() == 3) chk("len1_addr_literal", obs_q[2], 31);
    run_cfg(0, 32, 1, 32'h0, -1, 1'b1, 1'b0, 32);
    if (obs_q.size() == 32) begin
      chk("full_first_literal", obs_q[0], 0);
      chk("full_last_literal", obs_q[31], 31);
    end else chk("full_obs_len", obs_q.size(), 32);

    // start mid-run with a different config is ignored
    run_cfg(4, 3, 2, 32'h0, 2, 1'b0, 1'b0, 6);

    // reset during RUN after two reads
    exp_q.delete();
    for (int p = 0; p < 2; p++) for (int i = 0; i < 3; i++) exp_q.push_back(5'(4 + i));
    total = 6; n_rden = 0; n_valid = 0; err_mode = 1'b0; first_rd = -1;
    @(posedge clk); #1;
    bus.cfg_base = 5'd4; bus.cfg_len = 6'd3; bus.cfg_rep = 16'd2; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 20 && n_rden < 2; c++) begin
      @(posedge clk); #1;
    end
    chk("rst_reads_before", n_rden, 2);
    chk_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_midrun_outputs", {bus.rdAddr, bus.rden, bus.seq_valid, bus.seq_last, bus.busy, bus.done, bus.cfg_err}, 0);
    exp_q.delete(); total = 0; n_valid = 0;
    chk_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("rst_no_done", bus.done, 0);
      chk("rst_idle", bus.busy, 0);
    end
    run_cfg(5, 2, 2, 32'b100, -1, 1'b0, 1'b0, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
